// File: rtl/fb_fill_engine.sv
// fb_fill_engine: SDRAM fill engine writing a solid or gradient colour run; FB_FILL_RECT_EN adds multi-line rectangle fills
module fb_fill_engine #(
  parameter int CNT_W = 24,
  parameter int INCR  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [23:0]      base_addr_x16_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [15:0]      color_i,
`ifdef FB_FILL_RECT_EN
  input  logic [CNT_W-1:0] lines_i,
  input  logic [23:0]      stride_x16_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             sdram_wr,
  output logic [23:0]      sdram_addr_x16,
  output logic [15:0]      sdram_wdata,
  output logic [1:0]       sdram_wmask,
  input  logic             sdram_rdy,
  input  logic             sdram_ack
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FINISH} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_q;
  logic             last_line;
  logic             zero_cmd;
`ifdef FB_FILL_RECT_EN
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] lines_q;
  logic [23:0]      line_addr;
  logic [23:0]      stride_q;
  assign last_line = lines_q == CNT_W'(1);
  assign zero_cmd  = count_i == '0 || lines_i == '0;
`else
  assign last_line = 1'b1;
  assign zero_cmd  = count_i == '0;
`endif
  assign sdram_wmask = 2'b11;
  // command sequencer; sdram_addr_x16/sdram_wdata double as the working address and colour
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      sdram_wr       <= 1'b0;
      sdram_addr_x16 <= '0;
      sdram_wdata    <= '0;
      cnt_q          <= '0;
      abort_q        <= 1'b0;
`ifdef FB_FILL_RECT_EN
      count_q        <= '0;
      lines_q        <= '0;
      line_addr      <= '0;
      stride_q       <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          busy_o         <= 1'b1;
          sdram_addr_x16 <= base_addr_x16_i;
          sdram_wdata    <= color_i;
          cnt_q          <= count_i;
          abort_q        <= 1'b0;
          state          <= zero_cmd ? FINISH : ISSUE;
`ifdef FB_FILL_RECT_EN
          count_q        <= count_i;
          lines_q        <= lines_i;
          line_addr      <= base_addr_x16_i;
          stride_q       <= stride_x16_i;
`endif
        end
        ISSUE: begin
          if (abort_i) state <= FINISH;
          else if (sdram_rdy) begin
            sdram_wr <= 1'b1;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (abort_i) abort_q <= 1'b1;
          if (sdram_ack) begin
            sdram_wr    <= 1'b0;
            sdram_wdata <= sdram_wdata + 16'(INCR);
            state       <= (abort_q || abort_i || (cnt_q == CNT_W'(1) && last_line)) ? FINISH : ISSUE;
`ifdef FB_FILL_RECT_EN
            if (cnt_q == CNT_W'(1)) begin
              sdram_addr_x16 <= line_addr + stride_q;
              line_addr      <= line_addr + stride_q;
              cnt_q          <= count_q;
              lines_q        <= lines_q - CNT_W'(1);
            end else begin
              sdram_addr_x16 <= sdram_addr_x16 + 24'd1;
              cnt_q          <= cnt_q - CNT_W'(1);
            end
`else
            sdram_addr_x16 <= sdram_addr_x16 + 24'd1;
            cnt_q          <= cnt_q - CNT_W'(1);
`endif
          end
        end
        FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: directed bench for fb_fill_engine, solid (INCR=0) and gradient (INCR=1) instances in lockstep
module tb_fb_fill_engine;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_i, start_i, abort_i, sdram_rdy, sdram_ack;
  logic [23:0] base_addr_x16_i, count_i;
  logic [15:0] color_i;
`ifdef FB_FILL_RECT_EN
  logic [23:0] lines_i, stride_x16_i;
`endif
  logic busy_o, done_o, sdram_wr, g_busy, g_done, g_wr;
  logic [23:0] sdram_addr_x16, g_addr;
  logic [15:0] sdram_wdata, g_wdata;
  logic [1:0] sdram_wmask, g_wmask;

  fb_fill_engine #(.CNT_W(24), .INCR(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_x16_i(base_addr_x16_i), .count_i(count_i), .color_i(color_i),
`ifdef FB_FILL_RECT_EN
    .lines_i(lines_i), .stride_x16_i(stride_x16_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .sdram_wr(sdram_wr), .sdram_addr_x16(sdram_addr_x16),
    .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask), .sdram_rdy(sdram_rdy), .sdram_ack(sdram_ack));

  fb_fill_engine #(.CNT_W(24), .INCR(1)) dut_g (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_x16_i(base_addr_x16_i), .count_i(count_i), .color_i(color_i),
`ifdef FB_FILL_RECT_EN
    .lines_i(lines_i), .stride_x16_i(stride_x16_i),
`endif
    .busy_o(g_busy), .done_o(g_done), .sdram_wr(g_wr), .sdram_addr_x16(g_addr),
    .sdram_wdata(g_wdata), .sdram_wmask(g_wmask), .sdram_rdy(sdram_rdy), .sdram_ack(sdram_ack));

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [23:0] wa[$];
  logic [15:0] wd[$], gd[$];
  int done_cnt = 0, age = 0;
  logic ack_en = 1'b1, force_ack = 1'b0, wr_prev = 1'b0;
  logic [23:0] pa = '0;
  logic [15:0] pd = '0;

  // write capture, protocol checks and an ack responder answering two cycles after each request
  initial begin
    sdram_ack = 1'b0;
    forever begin
      @(negedge clk_i);
      if (sdram_wr && !wr_prev) begin
        wa.push_back(sdram_addr_x16);
        wd.push_back(sdram_wdata);
        gd.push_back(g_wdata);
        chk("wmask", 32'(sdram_wmask), 32'h3);
      end
      if (sdram_wr && wr_prev) begin
        chk("hold_addr", 32'(sdram_addr_x16), 32'(pa));
        chk("hold_data", 32'(sdram_wdata), 32'(pd));
      end
      if (sdram_wr || g_wr) chk("g_wr_lockstep", 32'(g_wr), 32'(sdram_wr));
      if (done_o) begin
        done_cnt++;
        chk("done_vs_wr", 32'(sdram_wr), 32'h0);
      end
      if (!ack_en) begin
        sdram_ack = force_ack;
        age = 0;
      end else if (sdram_ack) begin
        sdram_ack = 1'b0;
        age = 0;
      end else if (sdram_wr) begin
        age++;
        if (age >= 2) sdram_ack = 1'b1;
      end
      wr_prev = sdram_wr;
      pa = sdram_addr_x16;
      pd = sdram_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] base;
    logic [23:0] cnt;
    logic [15:0] col;
    int          n;
    logic [23:0] last_a;
    logic [15:0] last_g;
  } vec_t;
  vec_t vt[5];

  task automatic clear();
    wa.delete(); wd.delete(); gd.delete();
    done_cnt = 0;
  endtask

  task automatic start_cmd(input logic [23:0] b, input logic [23:0] c, input logic [15:0] col, input logic ab);
    @(negedge clk_i);
    base_addr_x16_i = b; count_i = c; color_i = col; start_i = 1'b1; abort_i = ab;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'h1);
    repeat (2) @(negedge clk_i);
    chk({name, "_done_once"}, 32'(done_cnt), 32'h1);
    chk({name, "_busy_after"}, 32'(busy_o), 32'h0);
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!sdram_wr && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("wr_seen", 32'(sdram_wr), 32'h1);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; sdram_rdy = 1'b1;
    base_addr_x16_i = '0; count_i = '0; color_i = '0;
`ifdef FB_FILL_RECT_EN
    lines_i = 24'd1; stride_x16_i = '0;
`endif
    vt[0] = '{24'h001000, 24'd4, 16'hF800, 4, 24'h001003, 16'hF803};
    vt[1] = '{24'hFFFFFE, 24'd3, 16'hFFFF, 3, 24'h000000, 16'h0001};
    vt[2] = '{24'h000000, 24'd0, 16'h1234, 0, 24'h000000, 16'h0000};
    vt[3] = '{24'h123456, 24'd1, 16'h07E0, 1, 24'h123456, 16'h07E0};
    vt[4] = '{24'hABCDEF, 24'd5, 16'h001F, 5, 24'hABCDF3, 16'h0023};
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_wr", 32'(sdram_wr), 32'h0);
    chk("rst_addr", 32'(sdram_addr_x16), 32'h0);
    chk("rst_wdata", 32'(sdram_wdata), 32'h0);
    chk("rst_wmask", 32'(sdram_wmask), 32'h3);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int v = 0; v < 5; v++) begin
      clear();
      start_cmd(vt[v].base, vt[v].cnt, vt[v].col, 1'b0);
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_nwr", v), 32'(wa.size()), 32'(vt[v].n));
      for (int i = 0; i < wa.size(); i++) begin
        chk($sformatf("vec%0d_addr%0d", v, i), 32'(wa[i]), 32'(24'(vt[v].base + 24'(i))));
        chk($sformatf("vec%0d_data%0d", v, i), 32'(wd[i]), 32'(vt[v].col));
        chk($sformatf("vec%0d_grad%0d", v, i), 32'(gd[i]), 32'(16'(vt[v].col + 16'(i))));
      end
      if (vt[v].n > 0 && wa.size() == vt[v].n) begin
        chk($sformatf("vec%0d_last_addr", v), 32'(wa[vt[v].n-1]), 32'(vt[v].last_a));
        chk($sformatf("vec%0d_last_grad", v), 32'(gd[vt[v].n-1]), 32'(vt[v].last_g));
      end
    end

    clear();
    @(negedge clk_i);
    base_addr_x16_i = 24'h000050; count_i = '0; color_i = 16'h4321; start_i = 1'b1;
    @(negedge clk_i);
    chk("zero_done_c1", 32'(done_o), 32'h0);
    chk("zero_busy_c1", 32'(busy_o), 32'h1);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("zero_done_c2", 32'(done_o), 32'h1);
    chk("zero_busy_c2", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    chk("zero_done_c3", 32'(done_o), 32'h0);
    chk("zero_nwr", 32'(wa.size()), 32'h0);

    clear();
    sdram_rdy = 1'b0;
    start_cmd(24'h000200, 24'd3, 16'h5555, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_no_wr", 32'(sdram_wr), 32'h0);
      @(negedge clk_i);
    end
    chk("bp_busy", 32'(busy_o), 32'h1);
    sdram_rdy = 1'b1;
    wait_done("bp");
    chk("bp_nwr", 32'(wa.size()), 32'd3);
    for (int i = 0; i < wa.size(); i++) chk($sformatf("bp_addr%0d", i), 32'(wa[i]), 32'h200 + 32'(i));

    clear();
    start_cmd(24'h004000, 24'd8, 16'hAAAA, 1'b0);
    begin
      int n = 0;
      while (!(sdram_wr && wa.size() == 2) && n < 100) begin
        @(negedge clk_i);
        n++;
      end
    end
    chk("abw_in_word2", 32'(sdram_wr && wa.size() == 2), 32'h1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    wait_done("abw");
    chk("abw_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) chk("abw_addr1", 32'(wa[1]), 32'h004001);

    clear();
    sdram_rdy = 1'b0;
    start_cmd(24'h000400, 24'd4, 16'h1357, 1'b0);
    repeat (3) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    sdram_rdy = 1'b1;
    wait_done("abi");
    chk("abi_nwr", 32'(wa.size()), 32'h0);

    clear();
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abidle_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    chk("abidle_done", 32'(done_cnt), 32'h0);

    clear();
    start_cmd(24'h000800, 24'd2, 16'h0F0F, 1'b1);
    wait_done("stab");
    chk("stab_nwr", 32'(wa.size()), 32'd2);

    clear();
    start_cmd(24'h000100, 24'd3, 16'h1111, 1'b0);
    @(negedge clk_i);
    base_addr_x16_i = 24'h000900; count_i = 24'd1; color_i = 16'h2222; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("sbusy");
    chk("sbusy_nwr", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("sbusy_addr2", 32'(wa[2]), 32'h000102);
      chk("sbusy_data2", 32'(wd[2]), 32'h1111);
    end

    clear();
    ack_en = 1'b0;
    force_ack = 1'b0;
    start_cmd(24'h003000, 24'd4, 16'h7777, 1'b0);
    wait_wr();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rwa_wr", 32'(sdram_wr), 32'h0);
    chk("rwa_busy", 32'(busy_o), 32'h0);
    chk("rwa_done", 32'(done_o), 32'h0);
    chk("rwa_addr", 32'(sdram_addr_x16), 32'h0);
    chk("rwa_wdata", 32'(sdram_wdata), 32'h0);
    chk("rwa_wmask", 32'(sdram_wmask), 32'h3);
    rst_i = 1'b0;
    force_ack = 1'b1;
    @(negedge clk_i);
    force_ack = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("late_ack_wr", 32'(sdram_wr), 32'h0);
    chk("late_ack_busy", 32'(busy_o), 32'h0);
    chk("late_ack_done", 32'(done_cnt), 32'h0);
    ack_en = 1'b1;

    clear();
    start_cmd(24'h000040, 24'd2, 16'h0001, 1'b0);
    wait_done("recover");
    chk("recover_nwr", 32'(wa.size()), 32'd2);

`ifdef FB_FILL_RECT_EN
    begin
      logic [23:0] ra[6];
      ra = '{24'h000, 24'h001, 24'h280, 24'h281, 24'h500, 24'h501};
      clear();
      lines_i = 24'd3; stride_x16_i = 24'h000280;
      start_cmd(24'h000000, 24'd2, 16'h0003, 1'b0);
      wait_done("rect");
      chk("rect_nwr", 32'(wa.size()), 32'd6);
      for (int i = 0; i < 6 && i < wa.size(); i++) chk($sformatf("rect_addr%0d", i), 32'(wa[i]), 32'(ra[i]));
      clear();
      lines_i = 24'd0;
      start_cmd(24'h000000, 24'd2, 16'h0003, 1'b0);
      wait_done("rect0");
      chk("rect0_nwr", 32'(wa.size()), 32'h0);
      lines_i = 24'd1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
